// File: rtl/auto_save_const.sv
// auto_save_const: programs the last flash parameter block with the constant
// store contents through the shared BPI command engine (unlock, erase, poll,
// program/poll per word, then return the flash to read-array mode).
module auto_save_const #(
  parameter logic [5:0]  MAX_ADDR  = 6'd33,
  parameter logic [22:0] BASE_ADDR = 23'h7FC000,
  parameter logic [15:0] POLL_MAX  = 16'd65535
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        AS_START,
  input  logic        BUSY,
  input  logic        AS_DONE,
  input  logic [15:0] DATA_IN,
  input  logic [7:0]  STATUS_IN,
  output logic [22:0] AS_ADDR,
  output logic [15:0] AS_CMD_DATA_OUT,
  output logic [1:0]  AS_OP,
  output logic        AS_EXECUTE,
  output logic        AUTO_SAVE_ENA,
  output logic        CLR_AS_DONE,
  output logic [5:0]  AS_CNT,
  output logic [2:0]  AS_STATUS
);

  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  // Handshake phase of the current engine op.
  typedef enum logic [2:0] {
    PH_IDLE, PH_WAIT_BUSY, PH_EXEC, PH_WAIT_DONE, PH_CLR
  } phase_t;

  // Which op of the save sequence is in flight.
  typedef enum logic [2:0] {
    ST_UNLK1, ST_UNLK2, ST_ERASE, ST_ESTAT, ST_PROG, ST_PSTAT, ST_RDARR
  } step_t;

  phase_t      phase, phase_nxt;
  step_t       step, step_nxt;
  logic        aborting, aborting_nxt;
  logic [15:0] poll_cnt, poll_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [2:0]  status, status_nxt;
  logic [1:0]  op_q, op_nxt;
  logic [15:0] cmd_q, cmd_nxt;

  logic [1:0]  step_op;
  logic [15:0] step_cmd;
  logic [16:0] poll_inc;
  logic        flash_ready;
  logic        flash_err;

  assign poll_inc    = {1'b0, poll_cnt} + 17'd1;
  assign flash_ready = STATUS_IN[7];
  assign flash_err   = STATUS_IN[5] | STATUS_IN[4] | STATUS_IN[3] | STATUS_IN[1];

  // Op code and command/data word belonging to each step.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    step_op  = OP_CMD;
    step_cmd = 16'h0000;
    case (step)
      ST_UNLK1: begin step_op = OP_CMD;   step_cmd = 16'h0060; end
      ST_UNLK2: begin step_op = OP_CMD;   step_cmd = 16'h00D0; end
      ST_ERASE: begin step_op = OP_ERASE; step_cmd = 16'h0020; end
      ST_ESTAT: begin step_op = OP_READ;  step_cmd = 16'h0070; end
      ST_PROG:  begin step_op = OP_PROG;  step_cmd = DATA_IN;  end
      ST_PSTAT: begin step_op = OP_READ;  step_cmd = 16'h0070; end
      ST_RDARR: begin step_op = OP_CMD;   step_cmd = 16'h00FF; end
      default:  begin step_op = OP_CMD;   step_cmd = 16'h0000; end
    endcase
  end

  // Next-state logic: handshake phases plus step sequencing at each acknowledge.
  always_comb begin
    phase_nxt    = phase;
    step_nxt     = step;
    aborting_nxt = aborting;
    poll_nxt     = poll_cnt;
    cnt_nxt      = cnt;
    status_nxt   = status;
    op_nxt       = op_q;
    cmd_nxt      = cmd_q;
    case (phase)
      PH_IDLE: begin
        if (AS_START) begin
          phase_nxt    = PH_WAIT_BUSY;
          step_nxt     = ST_UNLK1;
          aborting_nxt = 1'b0;
          poll_nxt     = 16'd0;
          cnt_nxt      = 6'd0;
          status_nxt   = 3'b000;
        end
      end
      PH_WAIT_BUSY: begin
        // Op fields are captured at launch so they hold steady until the acknowledge.
        if (!BUSY) begin
          phase_nxt = PH_EXEC;
          op_nxt    = step_op;
          cmd_nxt   = step_cmd;
        end
      end
      PH_EXEC: phase_nxt = PH_WAIT_DONE;
      PH_WAIT_DONE: begin
        if (AS_DONE) phase_nxt = PH_CLR;
      end
      PH_CLR: begin
        status_nxt[0] = 1'b1;
        phase_nxt     = PH_WAIT_BUSY;
        case (step)
          ST_UNLK1: step_nxt = ST_UNLK2;
          ST_UNLK2: step_nxt = ST_ERASE;
          ST_ERASE: begin step_nxt = ST_ESTAT; poll_nxt = 16'd0; end
          ST_PROG:  begin step_nxt = ST_PSTAT; poll_nxt = 16'd0; end
          ST_ESTAT, ST_PSTAT: begin
            if (!flash_ready) begin
              if (poll_inc >= {1'b0, POLL_MAX}) begin
                step_nxt     = ST_RDARR;
                aborting_nxt = 1'b1;
              end else begin
                poll_nxt = poll_inc[15:0];
              end
            end else if (flash_err) begin
              step_nxt     = ST_RDARR;
              aborting_nxt = 1'b1;
            end else if (step == ST_ESTAT) begin
              step_nxt = ST_PROG;
            end else if (cnt == MAX_ADDR) begin
              step_nxt = ST_RDARR;
            end else begin
              cnt_nxt  = cnt + 6'd1;
              step_nxt = ST_PROG;
            end
          end
          ST_RDARR: begin
            phase_nxt = PH_IDLE;
            if (aborting) status_nxt[2] = 1'b1;
            else          status_nxt[1] = 1'b1;
          end
          default: phase_nxt = PH_IDLE;
        endcase
      end
      default: phase_nxt = PH_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: all state here is control/datapath, so every register is reset;
    // sequential state uses non-blocking assignments to avoid ordering races.
    if (!RST_N) begin
      phase    <= PH_IDLE;
      step     <= ST_UNLK1;
      aborting <= 1'b0;
      poll_cnt <= 16'd0;
      cnt      <= 6'd0;
      status   <= 3'b000;
      op_q     <= OP_CMD;
      cmd_q    <= 16'h0000;
    end else begin
      phase    <= phase_nxt;
      step     <= step_nxt;
      aborting <= aborting_nxt;
      poll_cnt <= poll_nxt;
      cnt      <= cnt_nxt;
      status   <= status_nxt;
      op_q     <= op_nxt;
      cmd_q    <= cmd_nxt;
    end
  end

  assign AS_EXECUTE      = (phase == PH_EXEC);
  assign CLR_AS_DONE     = (phase == PH_CLR);
  assign AUTO_SAVE_ENA   = (phase != PH_IDLE);
  assign AS_ADDR         = {BASE_ADDR[22:6], cnt};
  assign AS_CNT          = cnt;
  assign AS_STATUS       = status;
  assign AS_OP           = op_q;
  assign AS_CMD_DATA_OUT = cmd_q;

endmodule

// File: tb/tb_auto_save_const.sv
// Directed bench for auto_save_const with a small BPI engine model that logs
// every launched op. Two instances: default POLL_MAX and POLL_MAX=4.
module tb_auto_save_const;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic as_start = 1'b0;
  logic sel = 1'b0;
  logic hold_busy = 1'b0;
  int   mode = 0;

  logic        eng_busy, AS_DONE;
  logic [7:0]  STATUS_IN;
  logic        BUSY;
  logic [15:0] DATA_IN;

  logic [22:0] a0_addr, a1_addr;
  logic [15:0] a0_cmd, a1_cmd;
  logic [1:0]  a0_op, a1_op;
  logic        a0_exec, a1_exec, a0_ena, a1_ena, a0_clr, a1_clr;
  logic [5:0]  a0_cnt, a1_cnt;
  logic [2:0]  a0_st, a1_st;

  logic [22:0] s_addr;
  logic [15:0] s_cmd;
  logic [1:0]  s_op;
  logic        s_exec, s_ena, s_clr;
  logic [5:0]  s_cnt;
  logic [2:0]  s_st;

  logic [1:0]  log_op[$];
  logic [15:0] log_cmd[$];
  logic [22:0] log_addr[$];

  int total = 0;
  int bad = 0;
  int viol = 0;

  always #5 clk = ~clk;

  assign BUSY    = eng_busy | hold_busy;
  assign s_addr  = sel ? a1_addr : a0_addr;
  assign s_cmd   = sel ? a1_cmd  : a0_cmd;
  assign s_op    = sel ? a1_op   : a0_op;
  assign s_exec  = sel ? a1_exec : a0_exec;
  assign s_ena   = sel ? a1_ena  : a0_ena;
  assign s_clr   = sel ? a1_clr  : a0_clr;
  assign s_cnt   = sel ? a1_cnt  : a0_cnt;
  assign s_st    = sel ? a1_st   : a0_st;

  function automatic logic [15:0] const_word(input logic [5:0] i);
    return 16'h1234 + 16'(i) * 16'h0101;
  endfunction

  assign DATA_IN = const_word(s_cnt);

  auto_save_const dut (
    .CLK(clk), .RST_N(rst_n), .AS_START(as_start && !sel), .BUSY(BUSY),
    .AS_DONE(AS_DONE), .DATA_IN(DATA_IN), .STATUS_IN(STATUS_IN),
    .AS_ADDR(a0_addr), .AS_CMD_DATA_OUT(a0_cmd), .AS_OP(a0_op),
    .AS_EXECUTE(a0_exec), .AUTO_SAVE_ENA(a0_ena), .CLR_AS_DONE(a0_clr),
    .AS_CNT(a0_cnt), .AS_STATUS(a0_st)
  );

  auto_save_const #(.POLL_MAX(16'd4)) dut_t (
    .CLK(clk), .RST_N(rst_n), .AS_START(as_start && sel), .BUSY(BUSY),
    .AS_DONE(AS_DONE), .DATA_IN(DATA_IN), .STATUS_IN(STATUS_IN),
    .AS_ADDR(a1_addr), .AS_CMD_DATA_OUT(a1_cmd), .AS_OP(a1_op),
    .AS_EXECUTE(a1_exec), .AUTO_SAVE_ENA(a1_ena), .CLR_AS_DONE(a1_clr),
    .AS_CNT(a1_cnt), .AS_STATUS(a1_st)
  );

  // Engine model: 3-cycle BUSY per op, AS_DONE held until CLR, scenario status.
  logic [1:0] bcnt;
  logic [1:0] cur_op;
  int         pre_reads;
  logic       prog_seen;
  logic [5:0] last_prog;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy  <= 1'b0;
      AS_DONE   <= 1'b0;
      STATUS_IN <= 8'h00;
      bcnt      <= 2'd0;
      cur_op    <= 2'b00;
      pre_reads <= 0;
      prog_seen <= 1'b0;
      last_prog <= 6'd0;
      log_op.delete();
      log_cmd.delete();
      log_addr.delete();
    end else begin
      if (s_exec) begin
        eng_busy <= 1'b1;
        bcnt     <= 2'd3;
        cur_op   <= s_op;
        log_op.push_back(s_op);
        log_cmd.push_back(s_cmd);
        log_addr.push_back(s_addr);
        if (s_op == 2'b01) begin
          prog_seen <= 1'b1;
          last_prog <= s_addr[5:0];
        end
      end else if (eng_busy) begin
        if (bcnt == 2'd1) begin
          eng_busy <= 1'b0;
          AS_DONE  <= 1'b1;
          if (cur_op == 2'b10) begin
            case (mode)
              1: begin
                if (!prog_seen) begin
                  STATUS_IN <= (pre_reads < 5) ? 8'h00 : 8'h80;
                  pre_reads <= pre_reads + 1;
                end else STATUS_IN <= 8'h80;
              end
              2: STATUS_IN <= (prog_seen && last_prog == 6'd7) ? 8'h90 : 8'h80;
              3: STATUS_IN <= 8'h00;
              default: STATUS_IN <= 8'h80;
            endcase
          end
        end else begin
          bcnt <= bcnt - 2'd1;
        end
      end
      if (s_clr) AS_DONE <= 1'b0;
    end
  end

  // Handshake monitor on the selected instance.
  logic p_done = 1'b0, p_clr = 1'b0, p_exec = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_done = 1'b0; p_clr = 1'b0; p_exec = 1'b0;
    end else begin
      if (s_exec && s_clr) viol++;
      if (s_exec && BUSY) viol++;
      if (s_exec && p_exec) viol++;
      if (s_clr !== (p_done && !p_clr)) viol++;
      p_done = AS_DONE; p_clr = s_clr; p_exec = s_exec;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) as_start = 1'b1;
    @(negedge clk) as_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (s_ena && n < 5000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (s_ena !== 1'b0) begin
      bad++;
      $display("FAIL %s: timeout, ena=%b required 0", name, s_ena);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({s_exec, s_clr, s_ena, s_cnt, s_st, s_op, s_cmd} !== 30'd0) begin
      bad++;
      $display("FAIL %s: exec=%b clr=%b ena=%b cnt=%0d st=%b op=%b cmd=%h required all zero",
               name, s_exec, s_clr, s_ena, s_cnt, s_st, s_op, s_cmd);
    end
  endtask

  task automatic check_op(input string name, input int i, input logic [1:0] op,
                          input logic [15:0] cmd);
    total++;
    if (i >= log_op.size()) begin
      bad++;
      $display("FAIL %s: op %0d missing (log size %0d)", name, i, log_op.size());
    end else if (log_op[i] !== op || log_cmd[i] !== cmd) begin
      bad++;
      $display("FAIL %s: op %0d got %b/%h required %b/%h", name, i, log_op[i], log_cmd[i], op, cmd);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    do_reset();
    check_reset_outputs("after_reset");
  endtask

  task automatic test_nominal();
    int j;
    mode = 0; sel = 1'b0;
    do_reset();
    pulse_start();
    check_val("ena_after_start", int'(s_ena), 1);
    check_val("no_exec_with_ena", int'(s_exec), 0);
    wait_idle("nominal_idle");
    check_val("nominal_ops", log_op.size(), 73);
    check_op("unlk1", 0, 2'b00, 16'h0060);
    check_op("unlk2", 1, 2'b00, 16'h00D0);
    check_op("erase", 2, 2'b11, 16'h0020);
    check_op("estat", 3, 2'b10, 16'h0070);
    for (int w = 0; w < 34; w++) begin
      j = 4 + 2 * w;
      check_op("prog", j, 2'b01, const_word(6'(w)));
      if (j < log_addr.size()) check_val("prog_addr", int'(log_addr[j]), 32'h7FC000 + w);
      check_op("pstat", j + 1, 2'b10, 16'h0070);
    end
    check_op("rdarr", 72, 2'b00, 16'h00FF);
    check_val("nominal_status", int'(s_st), 3'b011);
    check_val("nominal_cnt", int'(s_cnt), 33);
    check_val("nominal_ena", int'(s_ena), 0);
  endtask

  task automatic test_erase_poll();
    mode = 1; sel = 1'b0;
    do_reset();
    pulse_start();
    wait_idle("epoll_idle");
    for (int i = 3; i < 9; i++) check_op("epoll_estat", i, 2'b10, 16'h0070);
    check_op("epoll_first_prog", 9, 2'b01, const_word(6'd0));
    if (log_addr.size() > 9) check_val("epoll_addr", int'(log_addr[9]), 32'h7FC000);
    check_val("epoll_ops", log_op.size(), 78);
    check_val("epoll_status", int'(s_st), 3'b011);
  endtask

  task automatic test_prog_error();
    mode = 2; sel = 1'b0;
    do_reset();
    pulse_start();
    wait_idle("perr_idle");
    check_val("perr_ops", log_op.size(), 21);
    check_op("perr_prog7", 18, 2'b01, const_word(6'd7));
    check_op("perr_rdarr", 20, 2'b00, 16'h00FF);
    check_val("perr_status", int'(s_st), 3'b101);
    check_val("perr_cnt", int'(s_cnt), 7);
  endtask

  task automatic test_timeout();
    mode = 3; sel = 1'b1;
    do_reset();
    pulse_start();
    wait_idle("tmo_idle");
    check_val("tmo_ops", log_op.size(), 8);
    for (int i = 3; i < 7; i++) check_op("tmo_stat", i, 2'b10, 16'h0070);
    check_op("tmo_rdarr", 7, 2'b00, 16'h00FF);
    check_val("tmo_status", int'(s_st), 3'b101);
    sel = 1'b0;
  endtask

  task automatic test_handshake();
    int execs = 0;
    int n = 0;
    mode = 0; sel = 1'b0;
    do_reset();
    viol = 0;
    hold_busy = 1'b1;
    pulse_start();
    repeat (20) begin
      @(negedge clk);
      if (s_exec) execs++;
    end
    check_val("busy_hold_no_exec", execs, 0);
    hold_busy = 1'b0;
    while (!s_exec && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("exec_after_busy_low", int'(s_exec), 1);
    n = 0;
    while (log_op.size() < 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    pulse_start();
    wait_idle("hs_idle");
    check_val("hs_ignored_start_ops", log_op.size(), 73);
    check_val("hs_status", int'(s_st), 3'b011);
    check_val("hs_violations", viol, 0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mode = 0; sel = 1'b0;
    do_reset();
    pulse_start();
    while (!(s_exec && s_op == 2'b01 && s_cnt == 6'd12) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_reached_word12", int'(s_cnt), 12);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    check_val("rerun_cnt", int'(s_cnt), 0);
    wait_idle("rerun_idle");
    check_op("rerun_unlk1", 0, 2'b00, 16'h0060);
    check_val("rerun_ops", log_op.size(), 73);
    check_val("rerun_status", int'(s_st), 3'b011);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_erase_poll();
    test_prog_error();
    test_timeout();
    test_handshake();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/auto_save_const.md
# auto_save_const

Writer counterpart to the BPI constant auto-load path. On a start pulse it unlocks, erases and programs the last flash parameter block (base 0x7FC000) with MAX_ADDR+1 16-bit constant words, then returns the flash to read-array mode. It issues single operations to the shared BPI command engine through the same EXECUTE/BUSY/DONE/CLR handshake used by auto-load, and it polls the flash status register after every erase and program.

## Interface
- MAX_ADDR, 6'd33: index of the last word programmed; words 0..MAX_ADDR are written.
- BASE_ADDR, 23'h7FC000: block base address; bits [5:0] must be 0.
- POLL_MAX, 16'd65535: maximum status reads per erase/program before abort.

- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous reset, active-low.
- AS_START  in  1  one-cycle start request; honoured only in IDLE.
- BUSY  in  1  BPI engine busy; EXECUTE is never issued while it is high.
- AS_DONE  in  1  engine op-complete flag; held high until CLR_AS_DONE.
- DATA_IN  in  16  constant word for index AS_CNT (combinational from constant store).
- STATUS_IN  in  8  flash status register returned by the last read-status op.
- AS_ADDR  out  23  {BASE_ADDR[22:6], AS_CNT}.
- AS_CMD_DATA_OUT  out  16  command or data word for the current op.
- AS_OP  out  2  00 command write; 01 program word; 10 read; 11 block erase.
- AS_EXECUTE  out  1  one-cycle op launch.
- AUTO_SAVE_ENA  out  1  high from start until IDLE; grants engine mux to this block.
- CLR_AS_DONE  out  1  one-cycle acknowledge of AS_DONE.
- AS_CNT  out  6  current word index.
- AS_STATUS  out  3  [0] any op acknowledged, [1] completed, [2] aborted. Sticky, cleared only by reset or a new accepted start.

## Operation
- Step sequence (each step is one engine op): UNLK1 (00, 0x0060), UNLK2 (00, 0x00D0), ERASE (11, 0x0020), ESTAT (10, 0x0070), then per word PROG (01, DATA_IN), PSTAT (10, 0x0070), then RDARR (00, 0x00FF), then DONE -> IDLE.
- Every step: wait for BUSY=0, pulse AS_EXECUTE, wait for AS_DONE=1, pulse CLR_AS_DONE, then advance. AS_ADDR/AS_OP/AS_CMD_DATA_OUT are stable from the EXECUTE cycle until CLR_AS_DONE.
- Status steps: after CLR, evaluate STATUS_IN. If bit7=0, repeat the status step and increment the poll counter. If bit7=1 and any of bits 5,4,3,1 is set, go to ABORT. Otherwise advance. If the poll counter reaches POLL_MAX, go to ABORT. The poll counter clears on entry to each status phase.
- Word loop: after a good PSTAT, if AS_CNT==MAX_ADDR go to RDARR, else increment AS_CNT and go to PROG. AS_CNT never wraps past MAX_ADDR.
- ABORT: issue RDARR (0x00FF) to restore read mode, set AS_STATUS[2], then IDLE. AS_STATUS[1] stays 0.
- DONE: set AS_STATUS[1] for one transition into IDLE.
- AS_START outside IDLE is ignored. An accepted start clears AS_STATUS and AS_CNT.
- AUTO_SAVE_ENA is low in IDLE only.

## Timing
- Reset values: AS_EXECUTE=0, CLR_AS_DONE=0, AUTO_SAVE_ENA=0, AS_CNT=0, AS_STATUS=000, AS_OP=00, AS_CMD_DATA_OUT=0x0000, FSM in IDLE, poll counter 0.
- AS_START sampled high in IDLE: AUTO_SAVE_ENA goes high the next cycle. The first AS_EXECUTE fires no earlier than 1 cycle after that, and only with BUSY=0.
- AS_EXECUTE: exactly one cycle per op. Never asserted in the same cycle as CLR_AS_DONE.
- CLR_AS_DONE: one cycle, the cycle after AS_DONE is sampled high. The next op's EXECUTE comes at least 1 cycle after CLR.
- Status decision uses STATUS_IN sampled in the CLR cycle.
- Simultaneous BUSY=1 and a pending launch: hold the launch, keep outputs stable.
- RST_N low at any time, including mid-erase: all outputs go to reset values immediately. No recovery is attempted; the next start reruns the full sequence.

## Test plan
- Nominal: start, engine model with 3-cycle BUSY and STATUS_IN=0x80 -> ops in order 0x0060, 0x00D0, erase, 0x0070, then 34× (program 0x7FC000..0x7FC021, 0x0070), then 0x00FF. AS_STATUS ends 011, AS_CNT=33, ENA low.
- Erase polling: STATUS_IN=0x00 for 5 reads then 0x80 -> exactly 6 ESTAT ops, then programming starts at AS_ADDR 0x7FC000.
- Program error: STATUS_IN=0x90 on word 7 -> next op is 0x00FF, AS_STATUS=101, AS_CNT=7.
- Timeout (POLL_MAX=4 override): STATUS_IN stuck 0x00 after erase -> 4 status reads, then 0x00FF, then AS_STATUS=101.
- Handshake: BUSY held high 20 cycles before a launch -> no EXECUTE until BUSY low. Every EXECUTE is one cycle and CLR follows AS_DONE by one cycle. AS_START mid-sequence is ignored.
- Reset mid-program (word 12): RST_N low 2 cycles -> all outputs at reset values. A new start reruns from UNLK1 with AS_CNT=0.
